// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the WB/MDU producers and the register-file write port.
// master = producer/consumer side (bench, pipeline); slave = the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic              wb_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [CNT_W-1:0]  pend_count;

  modport master (
    output wb_we, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready, wb_stall, rf_we, rf_addr, rf_data, pend_count
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    output mdu_ready, wb_stall, rf_we, rf_addr, rf_data, pend_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the RF write port between writeback (priority) and a queued MDU source; 1-cycle grant-to-write latency.
// Backpressure: mdu_ready while the FIFO is not full; wb_stall (Moore) when a starved MDU entry is forced through.
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst_n,
  regfile_write_arbiter_if.slave io
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state, state_nxt;
  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [SW-1:0]     starve, starve_nxt;
  logic              push, wb_grant, fifo_grant, ready;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;

  assign ready = (count < CNT_W'(DEPTH));
  assign push  = io.mdu_valid && ready;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    wb_grant   = 1'b0;
    fifo_grant = 1'b0;
    count_nxt  = count;
    starve_nxt = starve;
    state_nxt  = state;

    case (state)
      IDLE:    wb_grant = io.wb_we;
      PEND: begin
        if (io.wb_we) wb_grant   = 1'b1;
        else          fifo_grant = 1'b1;
      end
      FORCE:   fifo_grant = 1'b1;
      default: ;
    endcase

    count_nxt = count + CNT_W'(push) - CNT_W'(fifo_grant);

    // Starvation is only counted against entries already queued, not a same-cycle push.
    if (count_nxt == '0 || fifo_grant)
      starve_nxt = '0;
    else if (state != IDLE && wb_grant && starve != SW'(STARVE_MAX))
      starve_nxt = starve + SW'(1);

    if (count_nxt == '0)                     state_nxt = IDLE;
    else if (starve_nxt == SW'(STARVE_MAX))  state_nxt = FORCE;
    else                                     state_nxt = PEND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      starve    <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      count  <= count_nxt;
      starve <= starve_nxt;
      if (push)       wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_grant) rd_ptr <= rd_ptr + PTR_W'(1);

      // Writes to r0 still consume the grant and update addr/data; only the enable is masked.
      if (wb_grant) begin
        rf_we_q   <= (io.wb_addr != '0);
        rf_addr_q <= io.wb_addr;
        rf_data_q <= io.wb_data;
      end else if (fifo_grant) begin
        rf_we_q   <= (head.addr != '0);
        rf_addr_q <= head.addr;
        rf_data_q <= head.data;
      end else begin
        rf_we_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: io.mdu_addr, data: io.mdu_data};
  end

  assign io.mdu_ready  = ready;
  assign io.wb_stall   = (state == FORCE);
  assign io.rf_we      = rf_we_q;
  assign io.rf_addr    = rf_addr_q;
  assign io.rf_data    = rf_data_q;
  assign io.pend_count = count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, hand sequences (starvation, async reset), random vs queue model.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int SMAX   = 4;
  localparam int NVEC   = 13;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall;
    logic        ready;
    logic [1:0]  pend;
  } vec_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t vt [NVEC];
  vec_t v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bus.wb_we     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.mdu_valid = mv;
    bus.mdu_addr  = ma;
    bus.mdu_data  = md;
  endtask

  // Random-phase reference model state
  ent_t        q[$];
  ent_t        h;
  int          starve;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_stall, m_ready, hold_wb, hold_mdu, wb_win, popped;
  int          pre;

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    //                 wb_we wb_addr wb_data        mv    mdu_addr mdu_data       rf_we rf_addr rf_data        stall ready pend
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 2'd0};
    vt[1]  = '{1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h11111111, 1'b0, 1'b1, 2'd0};
    vt[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h11111111, 1'b0, 1'b1, 2'd0};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'h11111111, 1'b0, 1'b1, 2'd1};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h12345678, 1'b0, 1'b1, 2'd0};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 32'h12345678, 1'b0, 1'b1, 2'd0};
    vt[6]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd0, 32'h77,       1'b1, 5'd3, 32'h33,       1'b0, 1'b1, 2'd1};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h77,       1'b0, 1'b1, 2'd0};
    vt[8]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd1, 32'hA,        1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 1'b1, 2'd1};
    vt[9]  = '{1'b1, 5'd8, 32'h88,       1'b1, 5'd2, 32'hB,        1'b1, 5'd8, 32'h88,       1'b0, 1'b0, 2'd2};
    vt[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'hC,        1'b1, 5'd1, 32'hA,        1'b0, 1'b1, 2'd1};
    vt[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'hC,        1'b1, 5'd2, 32'hB,        1'b0, 1'b1, 2'd1};
    vt[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'hC,        1'b0, 1'b1, 2'd0};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we",   32'(bus.rf_we), 32'd0);
    chk("reset_rf_addr", 32'(bus.rf_addr), 32'd0);
    chk("reset_rf_data", bus.rf_data, 32'd0);
    chk("reset_pend",    32'(bus.pend_count), 32'd0);
    chk("reset_ready",   32'(bus.mdu_ready), 32'd1);
    chk("reset_stall",   32'(bus.wb_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      v = vt[i];
      drive(v.wb_we, v.wb_addr, v.wb_data, v.mdu_valid, v.mdu_addr, v.mdu_data);
      tick();
      chk($sformatf("vec%0d_rf_we", i),   32'(bus.rf_we), 32'(v.rf_we));
      chk($sformatf("vec%0d_rf_addr", i), 32'(bus.rf_addr), 32'(v.rf_addr));
      chk($sformatf("vec%0d_rf_data", i), bus.rf_data, v.rf_data);
      chk($sformatf("vec%0d_stall", i),   32'(bus.wb_stall), 32'(v.stall));
      chk($sformatf("vec%0d_ready", i),   32'(bus.mdu_ready), 32'(v.ready));
      chk($sformatf("vec%0d_pend", i),    32'(bus.pend_count), 32'(v.pend));
    end

    // Starvation: one queued entry against continuous writeback.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd4, 32'h40 + 32'(i), (i == 0), 5'd6, 32'h66);
      tick();
      chk($sformatf("starve%0d_rf_data", i), bus.rf_data, 32'h40 + 32'(i));
      chk($sformatf("starve%0d_stall", i),   32'(bus.wb_stall), 32'(i == 4));
    end
    drive(1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'h0);
    tick();
    chk("forced_rf_we",   32'(bus.rf_we), 32'd1);
    chk("forced_rf_addr", 32'(bus.rf_addr), 32'd6);
    chk("forced_rf_data", bus.rf_data, 32'h66);
    chk("forced_stall_clear", 32'(bus.wb_stall), 32'd0);
    tick();
    chk("held_wb_addr", 32'(bus.rf_addr), 32'd4);
    chk("held_wb_data", bus.rf_data, 32'h45);

    // Async reset while FORCE with two queued entries.
    drive(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'hE1);
    tick();
    drive(1'b1, 5'd10, 32'h101, 1'b1, 5'd12, 32'hE2);
    tick();
    drive(1'b1, 5'd10, 32'h102, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 10 && !bus.wb_stall; i++) tick();
    chk("force_reached", 32'(bus.wb_stall), 32'd1);
    chk("force_pend",    32'(bus.pend_count), 32'd2);
    #2;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("arst_rf_we",   32'(bus.rf_we), 32'd0);
    chk("arst_rf_addr", 32'(bus.rf_addr), 32'd0);
    chk("arst_rf_data", bus.rf_data, 32'd0);
    chk("arst_pend",    32'(bus.pend_count), 32'd0);
    chk("arst_ready",   32'(bus.mdu_ready), 32'd1);
    chk("arst_stall",   32'(bus.wb_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_rst%0d_rf_we", i), 32'(bus.rf_we), 32'd0);
    end

    // Randomized traffic against the queue model.
    starve   = 0;
    m_addr   = '0;
    m_data   = '0;
    hold_wb  = 1'b0;
    hold_mdu = 1'b0;
    for (int c = 0; c < 600; c++) begin
      m_stall = (q.size() != 0) && (starve == SMAX);
      m_ready = (q.size() < DEPTH);
      chk($sformatf("rnd%0d_pend", c),  32'(bus.pend_count), 32'(q.size()));
      chk($sformatf("rnd%0d_ready", c), 32'(bus.mdu_ready), 32'(m_ready));
      chk($sformatf("rnd%0d_stall", c), 32'(bus.wb_stall), 32'(m_stall));

      if (!hold_wb) begin
        bus.wb_we   = ($urandom_range(0, 99) < 65);
        bus.wb_addr = 5'($urandom_range(0, 7));
        bus.wb_data = $urandom;
      end
      if (!hold_mdu) begin
        bus.mdu_valid = ($urandom_range(0, 99) < 45);
        bus.mdu_addr  = 5'($urandom_range(0, 7));
        bus.mdu_data  = $urandom;
      end

      pre    = q.size();
      wb_win = 1'b0;
      popped = 1'b0;
      m_we   = 1'b0;
      if (m_stall || (!bus.wb_we && pre != 0)) begin
        h      = q.pop_front();
        popped = 1'b1;
        m_we   = (h.a != 5'd0);
        m_addr = h.a;
        m_data = h.d;
      end else if (bus.wb_we) begin
        wb_win = 1'b1;
        m_we   = (bus.wb_addr != 5'd0);
        m_addr = bus.wb_addr;
        m_data = bus.wb_data;
      end
      if (bus.mdu_valid && m_ready) q.push_back('{a: bus.mdu_addr, d: bus.mdu_data});
      if (q.size() == 0 || popped)  starve = 0;
      else if (pre != 0 && wb_win)  starve = (starve < SMAX) ? starve + 1 : SMAX;

      hold_wb  = m_stall && bus.wb_we;
      hold_mdu = bus.mdu_valid && !m_ready;

      tick();
      chk($sformatf("rnd%0d_rf_we", c),   32'(bus.rf_we), 32'(m_we));
      chk($sformatf("rnd%0d_rf_addr", c), 32'(bus.rf_addr), 32'(m_addr));
      chk($sformatf("rnd%0d_rf_data", c), bus.rf_data, m_data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two producers: the in-order writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are queued in a small FIFO, and the writeback stage has priority. A starvation counter forces a queued MDU write through by stalling writeback for one cycle. The block sits between the writeback mux / MDU outputs and the register-file write inputs of the decode stage.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose arbitration before a forced grant (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wb_we  in  1  writeback stage requests a register write
- wb_addr  in  ADDR_W  writeback destination register
- wb_data  in  DATA_W  writeback data (output of writeback mux)
- mdu_valid  in  1  MDU result available
- mdu_addr  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU result
- mdu_ready  out  1  FIFO can accept; a transfer occurs when mdu_valid && mdu_ready
- wb_stall  out  1  writeback must hold its current request this cycle
- rf_we  out  1  register file write enable (registered)
- rf_addr  out  ADDR_W  register file write address (registered)
- rf_data  out  DATA_W  register file write data (registered)
- pend_count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- State machine:
  - IDLE: FIFO empty.
  - PEND: FIFO non-empty, starve_cnt < STARVE_MAX.
  - FORCE: FIFO non-empty, starve_cnt == STARVE_MAX.
- Grant rules, evaluated every cycle:
  - In IDLE or PEND with wb_we=1: writeback wins.
  - In PEND with wb_we=0: the FIFO head wins and is popped.
  - In FORCE: the FIFO head wins regardless of wb_we, and wb_stall=1. The stalled writeback request is re-presented next cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) in each cycle where the FIFO is non-empty and writeback wins.
  - Clears to 0 on any FIFO grant and whenever the FIFO becomes empty.
- Transitions:
  - IDLE→PEND on push.
  - PEND→FORCE when starve_cnt reaches STARVE_MAX.
  - FORCE→PEND or IDLE after the forced pop, depending on remaining occupancy.
  - PEND→IDLE when the last entry pops with no push in the same cycle.
- mdu_ready = (pend_count < DEPTH). It depends on registered state only, with no same-cycle pop bypass.
  - Consequence: a full FIFO refuses a push even in a cycle where it pops.
- No bypass from mdu_* to rf_*. A pushed entry is grantable at the earliest in the following cycle.
- Push and pop in the same cycle (not full) leave occupancy unchanged. FIFO order is strictly preserved.
- Writes to register 0:
  - A granted request with address 0 consumes its grant (pop or WB slot).
  - rf_we is driven 0 for it; rf_addr and rf_data still update.
- Ordering between the WB and MDU sources is the hazard unit's responsibility. This block guarantees order only within the MDU source.
- Pointer arithmetic is modulo DEPTH. pend_count ranges 0..DEPTH.

## Timing
- Reset (asynchronous, rst_n=0):
  - rf_we=0, rf_addr=0, rf_data=0.
  - FIFO pointers=0, pend_count=0, starve_cnt=0, state=IDLE.
  - Resulting outputs: mdu_ready=1, wb_stall=0.
  - Reset asserted mid-operation discards all queued MDU results.
- Latency:
  - Granted request in cycle N → rf_we/rf_addr/rf_data valid in cycle N+1 for exactly one cycle.
  - MDU minimum: push in cycle N → register file written in cycle N+2.
- wb_stall is a Moore output (asserted exactly while in FORCE), never combinationally dependent on wb_we.
- mdu_ready and pend_count are Moore outputs.
- Idle cycle (no grant): rf_we=0; rf_addr and rf_data hold their previous values.

## Test plan
- Reset then WB-only traffic: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF in cycle 1 → rf_we=1, rf_addr=5, rf_data=0xDEADBEEF in cycle 2. mdu_ready=1 and wb_stall=0 throughout.
- Single MDU result with wb_we=0: push addr=9, data=0x12345678 in cycle 1 → pend_count=1 in cycle 2, rf write to 9 in cycle 3, pend_count=0 and state IDLE in cycle 3.
- Starvation with STARVE_MAX=4:
  - One MDU entry pushed, wb_we held at 1.
  - wb_stall=1 in exactly the 5th cycle after the push.
  - The MDU write appears next cycle.
  - The held WB write follows in the cycle after that, with the WB data unchanged.
- Full FIFO, DEPTH=2: push 2 entries while wb_we=1 → mdu_ready=0. A third mdu_valid is held until a pop; its data is written third, in order (values 0xA, 0xB, 0xC).
- Register 0: WB grant with addr=0 → rf_we stays 0. A queued MDU entry with addr=0 pops, rf_we=0, and pend_count decrements.
- Async reset with 2 entries queued and state FORCE → outputs return to reset values immediately. After release, no queued data is ever written.
